// File: rtl/ext_mem_responder.sv
// Fixed-latency, byte-addressed, little-endian memory responder for the accelerator's Mout_*/M_* port.
// Each channel runs IDLE -> WAIT -> RESP; the access itself is performed on the edge into RESP.
module ext_mem_responder #(
    parameter int CHANNELS    = 2,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 64,
    parameter int SIZE_W      = 7,
    parameter int MEM_BYTES   = 128,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        Mout_oe_ram,
    input  logic [CHANNELS-1:0]        Mout_we_ram,
    input  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram,
    input  logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram,
    input  logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size,
    output logic [CHANNELS*DATA_W-1:0] M_Rdata_ram,
    output logic [CHANNELS-1:0]        M_DataRdy,
    output logic                       err_sticky
);
    localparam int BYTES_W   = DATA_W / 8;
    localparam int NB_W      = $clog2(BYTES_W + 1);
    localparam int AW1       = ADDR_W + 1;
    localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    function automatic logic size_legal(input logic [SIZE_W-1:0] size);
        logic ok;
        ok = 1'b0;
        for (int bits = 8; bits <= DATA_W; bits = bits * 2)
            if (int'(size) == bits) ok = 1'b1;
        return ok;
    endfunction

    function automatic logic [NB_W-1:0] size_bytes(input logic [SIZE_W-1:0] size);
        return NB_W'(size >> 3);
    endfunction

    // Bit offset of byte addr+k in the flat store; one extra address bit so the sum never wraps.
    function automatic logic [AW1+2:0] mem_bit(input logic [ADDR_W-1:0] addr, input int k);
        logic [AW1-1:0] byte_addr;
        byte_addr = {1'b0, addr} + AW1'(k);
        return {byte_addr, 3'b000};
    endfunction

    logic [MEM_BYTES*8-1:0]     mem;
    logic [CHANNELS-1:0]        fire;
    logic [CHANNELS-1:0]        op_wr;
    logic [CHANNELS-1:0]        op_bad;
    logic [CHANNELS*ADDR_W-1:0] op_addr;
    logic [CHANNELS*NB_W-1:0]   op_nb;
    logic [CHANNELS*DATA_W-1:0] op_wdata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t            state;
        logic [CNT_W-1:0]  cnt_q;
        logic              rdy_q;
        logic [ADDR_W-1:0] addr_q;
        logic [NB_W-1:0]   nb_q;
        logic [DATA_W-1:0] wdata_q;
        logic [DATA_W-1:0] rdata_q;
        logic              wr_q;
        logic              bad_q;
        logic [ADDR_W-1:0] req_addr;
        logic [NB_W-1:0]   req_nb;
        logic [DATA_W-1:0] req_wdata;
        logic              req_any;
        logic              req_bad;
        logic              req_wr;
        logic              req_fast;

        assign req_addr  = Mout_addr_ram[c*ADDR_W +: ADDR_W];
        assign req_nb    = size_bytes(Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
        assign req_wdata = Mout_Wdata_ram[c*DATA_W +: DATA_W];
        assign req_any   = Mout_oe_ram[c] | Mout_we_ram[c];
        assign req_bad   = (Mout_oe_ram[c] & Mout_we_ram[c])
                         | !size_legal(Mout_data_ram_size[c*SIZE_W +: SIZE_W])
                         | (({1'b0, req_addr} + AW1'(req_nb)) > AW1'(MEM_BYTES));
        // Illegal requests of either kind complete with read latency.
        assign req_wr    = Mout_we_ram[c] & !req_bad;
        assign req_fast  = req_wr ? (WRITE_DELAY == 1) : (READ_DELAY == 1);

        // A delay of 1 completes straight out of IDLE, so the operands come from the port.
        assign fire[c] = ((state == S_IDLE) && req_any && req_fast)
                       || ((state == S_WAIT) && (cnt_q <= CNT_W'(1)));
        assign op_addr[c*ADDR_W +: ADDR_W]  = (state == S_IDLE) ? req_addr  : addr_q;
        assign op_nb[c*NB_W +: NB_W]        = (state == S_IDLE) ? req_nb    : nb_q;
        assign op_wdata[c*DATA_W +: DATA_W] = (state == S_IDLE) ? req_wdata : wdata_q;
        assign op_wr[c]                     = (state == S_IDLE) ? req_wr    : wr_q;
        assign op_bad[c]                    = (state == S_IDLE) ? req_bad   : bad_q;

        always_ff @(posedge clock) begin
            if (!reset) begin
                state <= S_IDLE;
                cnt_q <= '0;
                rdy_q <= 1'b0;
            end else begin
                rdy_q <= fire[c];
                case (state)
                    S_IDLE: begin
                        if (req_any) begin
                            if (req_fast) begin
                                state <= S_RESP;
                            end else begin
                                state <= S_WAIT;
                                cnt_q <= req_wr ? CNT_W'(WRITE_DELAY - 1) : CNT_W'(READ_DELAY - 1);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q <= CNT_W'(1)) state <= S_RESP;
                        else                    cnt_q <= cnt_q - 1'b1;
                    end
                    S_RESP:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if ((state == S_IDLE) && req_any) begin
                addr_q  <= req_addr;
                nb_q    <= req_nb;
                wdata_q <= req_wdata;
                wr_q    <= req_wr;
                bad_q   <= req_bad;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                rdata_q <= '0;
            end else if (fire[c] && !op_wr[c]) begin
                for (int k = 0; k < BYTES_W; k++)
                    rdata_q[k*8 +: 8] <= (!op_bad[c] && (k < int'(op_nb[c*NB_W +: NB_W])))
                                         ? mem[mem_bit(op_addr[c*ADDR_W +: ADDR_W], k) +: 8] : 8'h00;
            end
        end

        assign M_Rdata_ram[c*DATA_W +: DATA_W] = rdata_q;
        assign M_DataRdy[c]                    = rdy_q;
    end

    // Later channels assign last, so the higher index wins on overlapping bytes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < BYTES_W; k++)
                    if (fire[c] && op_wr[c] && (k < int'(op_nb[c*NB_W +: NB_W])))
                        mem[mem_bit(op_addr[c*ADDR_W +: ADDR_W], k) +: 8] <= op_wdata[c*DATA_W + k*8 +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)                  err_sticky <= 1'b0;
        else if (|(fire & op_bad))   err_sticky <= 1'b1;
    end
endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: directed scenarios plus randomized two-channel traffic against a byte-array model.
module tb_ext_mem_responder;
    localparam int MEM_BYTES = 128;
    localparam int RD        = 2;
    localparam int WD        = 1;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   oe, we;
    logic [17:0]  addr;
    logic [127:0] wdata;
    logic [13:0]  size;
    logic [127:0] rdata;
    logic [1:0]   rdy;
    logic         err;

    logic         d3_reset;
    logic [1:0]   d3_oe, d3_we;
    logic [17:0]  d3_addr;
    logic [127:0] d3_wdata;
    logic [13:0]  d3_size;
    logic [127:0] d3_rdata;
    logic [1:0]   d3_rdy;
    logic         d3_err;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rdy_cyc [2];
    int          t0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        ref_err;

    ext_mem_responder dut (
        .clock(clock), .reset(reset),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
        .M_Rdata_ram(rdata), .M_DataRdy(rdy), .err_sticky(err)
    );

    ext_mem_responder #(.READ_DELAY(3)) dut3 (
        .clock(clock), .reset(d3_reset),
        .Mout_oe_ram(d3_oe), .Mout_we_ram(d3_we), .Mout_addr_ram(d3_addr),
        .Mout_Wdata_ram(d3_wdata), .Mout_data_ram_size(d3_size),
        .M_Rdata_ram(d3_rdata), .M_DataRdy(d3_rdy), .err_sticky(d3_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One transaction per channel (either may be idle); channel 1 may be issued one cycle late.
    task automatic do_op(input logic [1:0] o, input logic [1:0] w,
                         input logic [8:0] a0, input logic [8:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input int off1, input string tag);
        logic [8:0]  a [2];
        logic [63:0] d [2];
        logic [6:0]  s [2];
        int          off [2];
        int          fin [2];
        int          nb [2];
        logic        bad [2];
        logic        is_wr [2];
        logic [63:0] exp_rd [2];
        int          last;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
        off[0] = 0; off[1] = off1;
        last = 0;
        for (int c = 0; c < 2; c++) begin
            nb[c]     = int'(s[c]) / 8;
            bad[c]    = (o[c] && w[c]) || !(s[c] inside {7'd8, 7'd16, 7'd32, 7'd64})
                        || (int'(a[c]) + nb[c] > MEM_BYTES);
            is_wr[c]  = w[c] && !bad[c];
            exp_rd[c] = '0;
            if (!o[c] && !w[c]) fin[c] = -1;
            else                fin[c] = off[c] + (is_wr[c] ? WD : RD);
            if (fin[c] > last) last = fin[c];
        end
        for (int k = 1; k <= last; k++) begin
            for (int c = 0; c < 2; c++)
                if (fin[c] >= 0 && off[c] == k - 1) begin
                    oe[c] = o[c];
                    we[c] = w[c];
                    addr[c*9 +: 9]    = a[c];
                    wdata[c*64 +: 64] = d[c];
                    size[c*7 +: 7]    = s[c];
                end
            // Completions in the same cycle: all reads see memory before any of that cycle's writes.
            for (int c = 0; c < 2; c++)
                if (fin[c] == k && !is_wr[c] && !bad[c])
                    for (int b = 0; b < nb[c]; b++) exp_rd[c][b*8 +: 8] = ref_mem[int'(a[c]) + b];
            for (int c = 0; c < 2; c++)
                if (fin[c] == k && is_wr[c])
                    for (int b = 0; b < nb[c]; b++) ref_mem[int'(a[c]) + b] = d[c][b*8 +: 8];
            for (int c = 0; c < 2; c++)
                if (fin[c] == k && bad[c]) ref_err = 1'b1;
            step();
            for (int c = 0; c < 2; c++) begin
                check($sformatf("%s_rdy%0d_k%0d", tag, c, k), 64'(rdy[c]), 64'(fin[c] == k));
                if (fin[c] == k) begin
                    rdy_cyc[c] = cyc;
                    if (!is_wr[c]) check($sformatf("%s_rdata%0d", tag, c), rdata[c*64 +: 64], exp_rd[c]);
                    oe[c] = 1'b0;
                    we[c] = 1'b0;
                end
            end
        end
        step();
        check($sformatf("%s_rdy_after", tag), 64'(rdy), 64'd0);
        check($sformatf("%s_err", tag), 64'(err), 64'(ref_err));
    endtask

    initial begin
        reset = 1'b0; oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
        d3_reset = 1'b0; d3_oe = '0; d3_we = '0; d3_addr = '0; d3_wdata = '0; d3_size = '0;
        for (int b = 0; b < MEM_BYTES; b++) ref_mem[b] = 8'h00;
        ref_err = 1'b0;
        rdy_cyc[0] = 0; rdy_cyc[1] = 0;
        step();
        step();
        check("rst_rdy",    64'(rdy), 64'd0);
        check("rst_rdata0", rdata[63:0], 64'd0);
        check("rst_rdata1", rdata[127:64], 64'd0);
        check("rst_err",    64'(err), 64'd0);
        reset = 1'b1;

        do_op(2'b00, 2'b01, 9'h010, 9'h000, 64'hDEADBEEF, 64'd0, 7'd32, 7'd8, 0, "wr_10");
        do_op(2'b01, 2'b00, 9'h010, 9'h000, 64'd0, 64'd0, 7'd32, 7'd8, 0, "rd_10");
        check("rd_10_val", rdata[63:0], 64'h00000000DEADBEEF);
        do_op(2'b01, 2'b00, 9'h011, 9'h000, 64'd0, 64'd0, 7'd8, 7'd8, 0, "rd_11");
        check("rd_11_val", rdata[63:0], 64'h00000000000000BE);

        do_op(2'b01, 2'b00, 9'h000, 9'h000, 64'd0, 64'd0, 7'd64, 7'd8, 0, "b2b_0");
        t0 = rdy_cyc[0];
        do_op(2'b01, 2'b00, 9'h008, 9'h000, 64'd0, 64'd0, 7'd64, 7'd8, 0, "b2b_1");
        check("b2b_gap1", 64'(rdy_cyc[0] - t0), 64'd3);
        t0 = rdy_cyc[0];
        do_op(2'b01, 2'b00, 9'h010, 9'h000, 64'd0, 64'd0, 7'd64, 7'd8, 0, "b2b_2");
        check("b2b_gap2", 64'(rdy_cyc[0] - t0), 64'd3);
        check("b2b_val", rdata[63:0], 64'h00000000DEADBEEF);

        do_op(2'b00, 2'b11, 9'h020, 9'h020, 64'h11, 64'h22, 7'd8, 7'd8, 0, "ww_20");
        do_op(2'b01, 2'b00, 9'h020, 9'h000, 64'd0, 64'd0, 7'd8, 7'd8, 0, "rd_20");
        check("ww_20_winner", rdata[63:0], 64'h22);
        do_op(2'b01, 2'b10, 9'h030, 9'h030, 64'd0, 64'h55, 7'd8, 7'd8, 1, "rw_30");
        check("rw_30_old", rdata[63:0], 64'h00);
        do_op(2'b10, 2'b00, 9'h000, 9'h030, 64'd0, 64'd0, 7'd8, 7'd8, 0, "rd_30");
        check("rd_30_new", rdata[127:64], 64'h55);

        do_op(2'b00, 2'b10, 9'h000, 9'h07F, 64'd0, 64'h5A, 7'd8, 7'd8, 0, "wr_7f");
        do_op(2'b01, 2'b00, 9'h07F, 9'h000, 64'd0, 64'd0, 7'd8, 7'd8, 0, "rd_7f");
        check("rd_7f_val", rdata[63:0], 64'h5A);
        check("top_byte_no_err", 64'(err), 64'd0);

        do_op(2'b10, 2'b00, 9'h000, 9'h07C, 64'd0, 64'd0, 7'd8, 7'd64, 0, "oor_7c");
        check("oor_7c_rdata", rdata[127:64], 64'd0);
        check("oor_7c_err", 64'(err), 64'd1);
        do_op(2'b01, 2'b00, 9'h010, 9'h000, 64'd0, 64'd0, 7'd16, 7'd8, 0, "legal_after");
        check("err_sticks", 64'(err), 64'd1);
        do_op(2'b01, 2'b00, 9'h07F, 9'h000, 64'd0, 64'd0, 7'd16, 7'd8, 0, "oor_7f16");
        do_op(2'b00, 2'b01, 9'h040, 9'h000, 64'hFFFFFF, 64'd0, 7'd24, 7'd8, 0, "sz24_wr");
        check("sz24_rdata", rdata[63:0], 64'd0);
        do_op(2'b10, 2'b10, 9'h000, 9'h044, 64'd0, 64'hFFFFFFFF, 7'd8, 7'd32, 0, "oewe");
        check("oewe_rdata", rdata[127:64], 64'd0);
        do_op(2'b01, 2'b00, 9'h040, 9'h000, 64'd0, 64'd0, 7'd64, 7'd8, 0, "rd_40");
        check("bad_no_write", rdata[63:0], 64'd0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  ro, rw;
            logic [8:0]  ra [2];
            logic [6:0]  rs [2];
            logic [63:0] rdv [2];
            for (int c = 0; c < 2; c++) begin
                int kind, sz;
                kind  = int'($urandom_range(0, 9));
                ro[c] = ((kind >= 1) && (kind <= 4)) || (kind == 9);
                rw[c] = (kind >= 5);
                sz    = 8 << $urandom_range(0, 3);
                if ($urandom_range(0, 15) == 0) sz = 24;
                rs[c] = 7'(sz);
                if ($urandom_range(0, 1) == 1) ra[c] = 9'($urandom_range(0, 15));
                else                           ra[c] = 9'($urandom_range(0, MEM_BYTES - sz / 8));
                if ($urandom_range(0, 19) == 0) ra[c] = 9'($urandom_range(MEM_BYTES - 8, 511));
                rdv[c] = {$urandom, $urandom};
            end
            do_op(ro, rw, ra[0], ra[1], rdv[0], rdv[1], rs[0], rs[1], int'($urandom_range(0, 1)), "rnd");
        end

        d3_reset = 1'b1;
        step();
        d3_we = 2'b01; d3_addr[8:0] = 9'h005; d3_size[6:0] = 7'd8; d3_wdata[63:0] = 64'hAB;
        step();
        check("d3_wr_rdy", 64'(d3_rdy), 64'd1);
        d3_we = 2'b00;
        step();
        check("d3_wr_idle", 64'(d3_rdy), 64'd0);
        d3_oe = 2'b01;
        step();
        check("d3_rd_w1", 64'(d3_rdy), 64'd0);
        step();
        check("d3_rd_w2", 64'(d3_rdy), 64'd0);
        step();
        check("d3_rd_rdy", 64'(d3_rdy), 64'd1);
        check("d3_rd_val", d3_rdata[63:0], 64'hAB);
        d3_oe = 2'b00;
        step();
        d3_oe = 2'b01;
        step();
        check("d3_abort_wait", 64'(d3_rdy), 64'd0);
        d3_reset = 1'b0;
        d3_oe = 2'b00;
        step();
        check("d3_abort_rdy",   64'(d3_rdy), 64'd0);
        check("d3_abort_rdata", d3_rdata[63:0], 64'd0);
        check("d3_abort_err",   64'(d3_err), 64'd0);
        step();
        check("d3_abort_slot", 64'(d3_rdy), 64'd0);
        d3_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("d3_quiet_%0d", k), 64'(d3_rdy), 64'd0);
        end
        d3_oe = 2'b01;
        step();
        step();
        step();
        check("d3_rd2_rdy", 64'(d3_rdy), 64'd1);
        check("d3_rd2_val", d3_rdata[63:0], 64'd0);
        d3_oe = 2'b00;
        step();
        check("d3_rd2_after", 64'(d3_rdy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
